receive_packet_buf: RTL and testbench
=====================================

Name: receive_packet_buf

Overview:
- Parametrised successor to the fixed 9-word packet receiver.
- Ingests packets word-serially over a valid/ready stream and computes the ones-complement checksum on the fly.
- Latches header fields from each good packet.
- Stores payloads into a SLOTS-deep message buffer by relative sequence number, including out-of-order arrivals. Tracks the next expected sequence number for the ACK path.
- Sits between the optical deserialiser and the TCP-style control FSM / screen display.

Parameters:
- DATA_WORDS, 4, payload words (32-bit) per packet; packet length PKT_WORDS = 5 + DATA_WORDS.
- SLOTS, 5, message buffer depth in packets; valid relative SN range 1..SLOTS.
- FILL_CHAR, 8'h20, byte loaded into every message byte on reset/clear.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-low (asserted at 0).
- isn, input, 32, initial sequence number; relative SN = word2 - isn (mod 2^32).
- clear, input, 1, synchronous buffer clear, active-high.
- in_data, input, 32, stream word; header words 1-5 first, MSW first.
- in_valid, input, 1, in_data valid.
- in_last, input, 1, final word of packet.
- in_ready, output, 1, block accepts a word when in_valid & in_ready.
- seq, output, 32, word2 of last good packet.
- ack, output, 32, word3 of last good packet.
- flags, output, 9, word4[24:16] of last good packet.
- rx_done, output, 1, one-cycle pulse per packet end (good or bad).
- rx_good, output, 1, checksum and length of that packet OK; valid with rx_done.
- rx_dup, output, 1, good packet whose slot was already filled; valid with rx_done.
- filled, output, SLOTS, bit i set = slot i (SN i+1) holds data.
- next_sn, output, 32, 1 + count of contiguous filled slots from slot 0.
- message, output, SLOTS*DATA_WORDS*32, slot 0 in LSBs; within a slot, data word 1 in MSBs.

Behaviour:
- Reset (reset=0, async) and clear (sync) give identical state:
  - seq, ack, flags = 0.
  - rx_done, rx_good, rx_dup = 0.
  - filled = 0; all message bytes = FILL_CHAR.
  - FSM = RECV; word counter = 0; checksum accumulator = 0.
- clear wins over a simultaneous commit. A packet in flight is discarded (counter and accumulator zeroed, FSM to DRAIN if in_last not yet seen, else RECV).
- FSM states:
  - RECV:
    - in_ready=1.
    - Each accepted word: accumulator += word[31:16] + word[15:0] (32-bit sum); counter++. Header words 2-4 go to shadow registers; data words go to a staging register.
    - in_last with counter+1 == PKT_WORDS -> CHECK.
    - in_last with counter+1 < PKT_WORDS (short) -> ERR.
    - Counter reaching PKT_WORDS without in_last (long) -> DRAIN.
  - DRAIN: in_ready=1; words discarded; accepted in_last -> ERR.
  - ERR: in_ready=0; rx_done=1, rx_good=0 for one cycle; -> RECV with counter/accumulator cleared.
  - CHECK:
    - in_ready=0.
    - Fold: s = acc[31:16] + acc[15:0]; f = s[15:0] + s[16].
    - Good iff f[15:0] == 16'hFFFF (checksum word included in the sum).
    - Compute rel = word2 - isn.
    - -> COMMIT.
  - COMMIT:
    - in_ready=0; rx_done=1; rx_good=good.
    - If good: update seq/ack/flags.
    - If good, 1<=rel<=SLOTS and filled[rel-1]=0: write staging data into slot rel-1 and set filled bit.
    - If good and the slot is already filled: rx_dup=1, no overwrite.
    - Good packets with rel outside 1..SLOTS (control packets, SN 0) update the header only.
    - Bad packets change nothing.
    - -> RECV with counter/accumulator cleared.
- Latency: in_last accepted at edge t -> rx_done high in cycle t+2. Outputs updated at the same edge that raises rx_done.
- Throughput: at most one packet per PKT_WORDS+2 cycles.
- next_sn and in_ready are combinational from registers; all other outputs are registered.
- in_valid=0 mid-packet stalls without timeout.
- rel arithmetic wraps mod 2^32. isn is sampled in CHECK only.

Decomposition:
- Shared package lasernet_pkg: HDR_WORDS=5, flag bit positions (FIN=0, SYN=1, RST=2, PSH=3, ACK=4), FSM state encodings.
- Sub-module ones_comp_fold: 32-bit accumulator in, 16-bit folded sum out, combinational. Reused by the transmit-side checksum generator.

Test Plan:
- Reset: hold reset=0, then release -> filled=0, next_sn=1, seq=ack=0, message all 8'h20 bytes, in_ready=1.
- In-order delivery: isn=1000; send SN 1001, 1002, 1003 with correct checksums -> filled=5'b00111, next_sn=4, rx_good pulses 3 times, each 2 cycles after in_last.
- Out-of-order and duplicate:
  - Send rel 3, then rel 1 -> filled=5'b00101, next_sn=2.
  - Resend rel 3 with different payload -> rx_dup=1, slot 2 unchanged.
  - Send rel 2 -> next_sn=4.
- Corrupt checksum: flip bit 0 of word 7 -> rx_done=1, rx_good=0; seq, filled and message unchanged.
- Length errors:
  - in_last on word 6 -> rx_good=0.
  - 11-word packet -> in_ready stays 1 through word 11, rx_good=0.
  - Next well-formed packet is accepted.
- Control and clear:
  - Good packet with rel=0 and flags=9'h002 -> flags=9'h002, filled unchanged.
  - Assert clear mid-packet -> buffer reset; the rest of that packet is drained without committing.

Source files
------------

// File: rtl/lasernet_pkg.sv
// Shared definitions for the lasernet packet path.
// Header layout, TCP-style flag bit positions and receive FSM states.
package lasernet_pkg;

    localparam int HDR_WORDS = 5;

    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;
    localparam int FLAG_PSH = 3;
    localparam int FLAG_ACK = 4;

    typedef enum logic [2:0] {
        ST_RECV   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_ERR    = 3'd2,
        ST_CHECK  = 3'd3,
        ST_COMMIT = 3'd4
    } rx_state_t;

endpackage

// File: rtl/ones_comp_fold.sv
// Folds a 32-bit ones-complement accumulator down to 16 bits.
// Shared with the transmit-side checksum generator.
module ones_comp_fold (
    input  logic [31:0] acc,
    output logic [15:0] sum
);

    logic [16:0] s;

    // first fold keeps the carry, second fold adds it back in
    assign s   = {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
    assign sum = s[15:0] + {15'd0, s[16]};

endmodule

// File: rtl/receive_packet_buf.sv
// Word-serial packet receiver with on-the-fly checksum and a
// sequence-indexed message buffer tolerant of reordering.
module receive_packet_buf
    import lasernet_pkg::*;
#(
    parameter int         DATA_WORDS = 4,
    parameter int         SLOTS      = 5,
    parameter logic [7:0] FILL_CHAR  = 8'h20
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [31:0]                      isn,
    input  logic                             clear,
    input  logic [31:0]                      in_data,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic [31:0]                      seq,
    output logic [31:0]                      ack,
    output logic [8:0]                       flags,
    output logic                             rx_done,
    output logic                             rx_good,
    output logic                             rx_dup,
    output logic [SLOTS-1:0]                 filled,
    output logic [31:0]                      next_sn,
    output logic [SLOTS*DATA_WORDS*32-1:0]   message
);

    localparam int PKT_WORDS = HDR_WORDS + DATA_WORDS;
    localparam int SW        = DATA_WORDS * 32;
    localparam int MW        = SLOTS * SW;
    localparam int CW        = $clog2(PKT_WORDS + 1);
    localparam int SIW       = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [MW-1:0] FILL_ALL = {(MW / 8){FILL_CHAR}};

    rx_state_t      state, state_nx;
    logic [CW-1:0]  cnt;
    logic [31:0]    acc;
    logic [31:0]    seq_sh, ack_sh;
    logic [8:0]     flags_sh;
    logic [SW-1:0]  stage;
    logic           good_q, hit_q;
    logic [SIW-1:0] slot_q;
    logic [15:0]    fold;
    logic [31:0]    rel;
    logic           take, at_end, run;

    ones_comp_fold u_fold (
        .acc (acc),
        .sum (fold)
    );

    assign in_ready = (state == ST_RECV) || (state == ST_DRAIN);
    assign take     = in_valid && in_ready;
    assign at_end   = (cnt == CW'(PKT_WORDS - 1));
    assign rel      = seq_sh - isn;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_RECV;
        else        state <= state_nx;
    end

    // next state; clear drops a packet in flight into DRAIN
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_RECV: begin
                if (take) begin
                    if (in_last)     state_nx = at_end ? ST_CHECK : ST_ERR;
                    else if (at_end) state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: if (take && in_last) state_nx = ST_ERR;
            ST_CHECK: state_nx = ST_COMMIT;
            default:  state_nx = ST_RECV;
        endcase
        if (clear) begin
            state_nx = ST_RECV;
            if (((state == ST_RECV) && ((cnt != '0) || take)) ||
                (state == ST_DRAIN)) begin
                if (!(take && in_last)) state_nx = ST_DRAIN;
            end
        end
    end

    // datapath: accumulate, capture header/data, judge and commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            acc      <= '0;
            seq_sh   <= '0;
            ack_sh   <= '0;
            flags_sh <= '0;
            stage    <= '0;
            good_q   <= 1'b0;
            hit_q    <= 1'b0;
            slot_q   <= '0;
            seq      <= '0;
            ack      <= '0;
            flags    <= '0;
            rx_done  <= 1'b0;
            rx_good  <= 1'b0;
            rx_dup   <= 1'b0;
            filled   <= '0;
            message  <= FILL_ALL;
        end else if (clear) begin
            cnt      <= '0;
            acc      <= '0;
            seq      <= '0;
            ack      <= '0;
            flags    <= '0;
            rx_done  <= 1'b0;
            rx_good  <= 1'b0;
            rx_dup   <= 1'b0;
            filled   <= '0;
            message  <= FILL_ALL;
        end else begin
            rx_done <= 1'b0;
            rx_good <= 1'b0;
            rx_dup  <= 1'b0;
            unique case (state)
                ST_RECV: begin
                    if (take) begin
                        cnt <= cnt + CW'(1);
                        acc <= acc + {16'd0, in_data[31:16]}
                                   + {16'd0, in_data[15:0]};
                        if (cnt == CW'(1)) seq_sh   <= in_data;
                        if (cnt == CW'(2)) ack_sh   <= in_data;
                        if (cnt == CW'(3)) flags_sh <= in_data[24:16];
                        if (cnt >= CW'(HDR_WORDS))
                            stage[(PKT_WORDS - 1 - int'(cnt)) * 32 +: 32]
                                <= in_data;
                    end
                end
                ST_ERR: begin
                    rx_done <= 1'b1;
                    cnt     <= '0;
                    acc     <= '0;
                end
                ST_CHECK: begin
                    good_q <= (fold == 16'hFFFF);
                    hit_q  <= (rel != 32'd0) && (rel <= 32'(SLOTS));
                    slot_q <= SIW'(rel - 32'd1);
                end
                ST_COMMIT: begin
                    rx_done <= 1'b1;
                    rx_good <= good_q;
                    cnt     <= '0;
                    acc     <= '0;
                    if (good_q) begin
                        seq   <= seq_sh;
                        ack   <= ack_sh;
                        flags <= flags_sh;
                        if (hit_q) begin
                            if (filled[slot_q]) begin
                                rx_dup <= 1'b1;
                            end else begin
                                filled[slot_q] <= 1'b1;
                                message[int'(slot_q) * SW +: SW] <= stage;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // count contiguous filled slots from slot 0
    always_comb begin
        next_sn = 32'd1;
        run     = 1'b1;
        for (int i = 0; i < SLOTS; i++) begin
            run = run & filled[i];
            if (run) next_sn = next_sn + 32'd1;
        end
    end

endmodule

// File: tb/tb_receive_packet_buf.sv
// Directed bench for receive_packet_buf: ordering, duplicates,
// checksum and length errors, control packets and clear.
module tb_receive_packet_buf;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  isn;
    logic         clear;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [31:0]  seq, ack, next_sn;
    logic [8:0]   flags;
    logic         rx_done, rx_good, rx_dup;
    logic [4:0]   filled;
    logic [639:0] message;

    int errors = 0;
    int checks = 0;
    logic [31:0]  pkt [0:15];
    logic [127:0] ex [0:4];
    bit           chk_rdy = 1'b0;

    localparam logic [127:0] FILL = {16{8'h20}};

    receive_packet_buf dut (
        .clk      (clk),
        .reset    (reset),
        .isn      (isn),
        .clear    (clear),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .seq      (seq),
        .ack      (ack),
        .flags    (flags),
        .rx_done  (rx_done),
        .rx_good  (rx_good),
        .rx_dup   (rx_dup),
        .filled   (filled),
        .next_sn  (next_sn),
        .message  (message)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pay(input logic [31:0] sn);
        return {sn, ~sn, sn ^ 32'hA5A5_A5A5, sn + 32'h1234_0000};
    endfunction

    task automatic build(input logic [31:0] sn, input logic [8:0] fl,
                         input logic [127:0] d);
        logic [31:0] s;
        pkt[0] = 32'hC0DE_0050;
        pkt[1] = sn;
        pkt[2] = sn + 32'h0100_0000;
        pkt[3] = {7'd0, fl, 16'h2000};
        pkt[4] = 32'd0;
        for (int j = 0; j < 4; j++) pkt[5 + j] = d[127 - 32 * j -: 32];
        pkt[9]  = 32'hDEAD_0009;
        pkt[10] = 32'hDEAD_000A;
        s = 32'd0;
        for (int i = 0; i < 9; i++)
            s = s + {16'd0, pkt[i][31:16]} + {16'd0, pkt[i][15:0]};
        while (s > 32'h0000_FFFF) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        pkt[4] = {16'd0, ~s[15:0]};
    endtask

    task automatic send_words(input int first, input int n,
                              input bit with_last);
        for (int i = first; i < n; i++) begin
            int w;
            @(negedge clk);
            w = 0;
            while (!in_ready && w < 8) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) chk("rdy_timeout", 0, 1);
            in_data  = pkt[i];
            in_valid = 1'b1;
            in_last  = with_last && (i == n - 1);
            if (chk_rdy) chk("long_rdy", in_ready, 1);
        end
    endtask

    task automatic wait_done(input string tag, input logic g,
                             input logic d, input bit lat_chk);
        bit seen;
        int k;
        seen = 1'b0;
        k = 0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            if (rx_done) begin
                seen = 1'b1;
                k = i;
            end
        end
        chk({tag, "_done"}, seen, 1);
        if (seen) begin
            if (lat_chk) chk({tag, "_lat"}, k, 3);
            chk({tag, "_good"}, rx_good, g);
            chk({tag, "_dup"}, rx_dup, d);
            @(negedge clk);
            chk({tag, "_pulse"}, rx_done, 0);
        end
    endtask

    task automatic good_pkt(input string tag, input logic [31:0] sn,
                            input logic [8:0] fl, input logic [127:0] d,
                            input logic dup);
        build(sn, fl, d);
        send_words(0, 9, 1);
        wait_done(tag, 1, dup, 1);
    endtask

    task automatic check_buf(input string tag, input logic [4:0] f,
                             input logic [31:0] nsn);
        chk({tag, "_filled"}, filled, f);
        chk({tag, "_next"}, next_sn, nsn);
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s_slot%0d", tag, i), message[i * 128 +: 128],
                ex[i]);
    endtask

    task automatic clear_pulse;
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 5; i++) ex[i] = FILL;
    endtask

    initial begin
        reset    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'd0;
        isn      = 32'd1000;
        for (int i = 0; i < 5; i++) ex[i] = FILL;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        check_buf("rst", 5'b00000, 1);
        chk("rst_seq", seq, 0);
        chk("rst_ack", ack, 0);
        chk("rst_flags", flags, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_done", rx_done, 0);

        good_pkt("io1", 1001, 9'h010, pay(1001), 0);
        ex[0] = pay(1001);
        good_pkt("io2", 1002, 9'h010, pay(1002), 0);
        ex[1] = pay(1002);
        good_pkt("io3", 1003, 9'h010, pay(1003), 0);
        ex[2] = pay(1003);
        check_buf("io", 5'b00111, 4);
        chk("io_seq", seq, 1003);
        chk("io_ack", ack, 32'h0100_0000 + 1003);
        chk("io_flags", flags, 9'h010);

        clear_pulse();
        check_buf("clr", 5'b00000, 1);
        chk("clr_seq", seq, 0);
        chk("clr_flags", flags, 0);

        good_pkt("ooo3", 1003, 9'h010, pay(1003), 0);
        ex[2] = pay(1003);
        good_pkt("ooo1", 1001, 9'h010, pay(1001), 0);
        ex[0] = pay(1001);
        check_buf("ooo", 5'b00101, 2);
        good_pkt("dup3", 1003, 9'h010, ~pay(1003), 1);
        check_buf("dup", 5'b00101, 2);
        chk("dup_seq", seq, 1003);
        good_pkt("ooo2", 1002, 9'h010, pay(1002), 0);
        ex[1] = pay(1002);
        check_buf("fill", 5'b00111, 4);

        build(1004, 9'h010, pay(1004));
        pkt[6] = pkt[6] ^ 32'd1;
        send_words(0, 9, 1);
        wait_done("bad_cs", 0, 0, 1);
        check_buf("bad_cs", 5'b00111, 4);
        chk("bad_cs_seq", seq, 1002);

        build(1004, 9'h010, pay(1004));
        send_words(0, 6, 1);
        wait_done("short", 0, 0, 0);
        chk("short_seq", seq, 1002);

        build(1004, 9'h010, pay(1004));
        send_words(0, 9, 0);
        chk_rdy = 1'b1;
        send_words(9, 11, 1);
        chk_rdy = 1'b0;
        wait_done("long", 0, 0, 0);
        check_buf("long", 5'b00111, 4);

        good_pkt("after", 1004, 9'h010, pay(1004), 0);
        ex[3] = pay(1004);
        check_buf("after", 5'b01111, 5);

        good_pkt("ctl", 1000, 9'h002, pay(7), 0);
        chk("ctl_flags", flags, 9'h002);
        chk("ctl_seq", seq, 1000);
        check_buf("ctl", 5'b01111, 5);

        build(1005, 9'h010, pay(1005));
        send_words(0, 4, 0);
        clear_pulse();
        check_buf("mid", 5'b00000, 1);
        chk("mid_seq", seq, 0);
        send_words(4, 9, 1);
        wait_done("drain", 0, 0, 0);
        check_buf("drain", 5'b00000, 1);
        chk("drain_seq", seq, 0);

        good_pkt("rec", 1001, 9'h010, pay(1001), 0);
        ex[0] = pay(1001);
        check_buf("rec", 5'b00001, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
